// File: rtl/dds_param_ctrl.sv
// Purpose : key-pulse driven parameter controller for the dds datapath (wave/freq/phase + auto sweep).
// Latency : a key pulse in cycle N is reflected on the registered outputs in cycle N+1.
// Backpr. : none; one key per cycle is accepted by priority, lower-priority pulses are dropped.
//
// Ports:
//   sys_clk, sys_rst_n            clock, async active-low reset
//   key_sweep/key_wave/key_freq_up/key_freq_dn/key_phase   1-cycle key pulses
//   wave_sel, freq, phase_ctrl    registered parameter outputs to dds
//   key_flag                      1-cycle strobe aligned with any parameter change
//   sweep_on                      high while the automatic sweep is running
module dds_param_ctrl #(
    parameter logic [6:0]  FREQ_MIN   = 7'd1,
    parameter logic [6:0]  FREQ_MAX   = 7'd100,
    parameter logic [6:0]  FREQ_INIT  = 7'd1,
    parameter logic [6:0]  FREQ_STEP  = 7'd1,
    parameter logic [4:0]  PHASE_STEP = 5'd1,
    parameter logic [23:0] DWELL_CNT  = 24'd4_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_sweep,
    input  logic       key_wave,
    input  logic       key_freq_up,
    input  logic       key_freq_dn,
    input  logic       key_phase,
    output logic       wave_sel,
    output logic [6:0] freq,
    output logic [4:0] phase_ctrl,
    output logic       key_flag,
    output logic       sweep_on
);

    typedef enum logic [1:0] {
        MANUAL   = 2'd0,
        SWEEP_UP = 2'd1,
        SWEEP_DN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        wave_sel_q, wave_sel_d;
    logic [6:0]  freq_q, freq_d;
    logic [4:0]  phase_ctrl_q, phase_ctrl_d;
    logic        key_flag_q, key_flag_d;
    logic        sweep_on_q, sweep_on_d;

    // Frequency arithmetic is carried one bit wider so limit checks never wrap.
    logic [7:0]  up_sum;
    logic        up_hits;
    logic [7:0]  dn_floor;
    logic        dn_hits;
    logic [6:0]  dn_val;
    logic        in_sweep;
    logic        dwell_done;

    always_comb begin
        up_sum     = {1'b0, freq_q} + {1'b0, FREQ_STEP};
        up_hits    = (up_sum >= {1'b0, FREQ_MAX});
        dn_floor   = {1'b0, FREQ_MIN} + {1'b0, FREQ_STEP};
        dn_hits    = ({1'b0, freq_q} <= dn_floor);
        // Only consumed when dn_hits is clear, so the subtraction cannot underflow.
        dn_val     = freq_q - FREQ_STEP;
        in_sweep   = (state_q != MANUAL);
        dwell_done = in_sweep && (cnt_q == DWELL_CNT);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wave_sel_d   = wave_sel_q;
        freq_d       = freq_q;
        phase_ctrl_d = phase_ctrl_q;
        key_flag_d   = 1'b0;

        if (key_sweep) begin
            // Entering or leaving sweep: freq is left as is, no strobe.
            cnt_d   = '0;
            state_d = in_sweep ? MANUAL : SWEEP_UP;
        end else begin
            // Sweep stepping runs alongside any accepted wave/phase key;
            // both share the single key_flag strobe.
            if (in_sweep) begin
                if (dwell_done) begin
                    cnt_d      = '0;
                    key_flag_d = 1'b1;
                    if (state_q == SWEEP_UP) begin
                        if (up_hits) begin
                            freq_d  = FREQ_MAX;
                            state_d = SWEEP_DN;
                        end else begin
                            freq_d = up_sum[6:0];
                        end
                    end else begin
                        if (dn_hits) begin
                            freq_d  = FREQ_MIN;
                            state_d = SWEEP_UP;
                        end else begin
                            freq_d = dn_val;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end

            // Manual freq keys are masked while sweeping, so they neither
            // act nor block a lower-priority phase key there.
            if (key_wave) begin
                wave_sel_d = ~wave_sel_q;
                key_flag_d = 1'b1;
            end else if (!in_sweep && key_freq_up) begin
                freq_d = up_hits ? FREQ_MAX : up_sum[6:0];
                if (freq_d != freq_q) begin
                    key_flag_d = 1'b1;
                end
            end else if (!in_sweep && key_freq_dn) begin
                freq_d = dn_hits ? FREQ_MIN : dn_val;
                if (freq_d != freq_q) begin
                    key_flag_d = 1'b1;
                end
            end else if (key_phase) begin
                phase_ctrl_d = phase_ctrl_q + PHASE_STEP;
                key_flag_d   = 1'b1;
            end
        end

        sweep_on_d = (state_d != MANUAL);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= MANUAL;
            cnt_q        <= '0;
            wave_sel_q   <= 1'b0;
            freq_q       <= FREQ_INIT;
            phase_ctrl_q <= '0;
            key_flag_q   <= 1'b0;
            sweep_on_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wave_sel_q   <= wave_sel_d;
            freq_q       <= freq_d;
            phase_ctrl_q <= phase_ctrl_d;
            key_flag_q   <= key_flag_d;
            sweep_on_q   <= sweep_on_d;
        end
    end

    assign wave_sel   = wave_sel_q;
    assign freq       = freq_q;
    assign phase_ctrl = phase_ctrl_q;
    assign key_flag   = key_flag_q;
    assign sweep_on   = sweep_on_q;

endmodule

// File: tb/tb_dds_param_ctrl.sv
// Purpose : directed self-checking bench for dds_param_ctrl (short dwell, low FREQ_MAX).
// Latency : inputs driven on the falling edge, outputs checked on the next falling edge.
// Backpr. : n/a.
module tb_dds_param_ctrl;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       key_sweep;
    logic       key_wave;
    logic       key_freq_up;
    logic       key_freq_dn;
    logic       key_phase;
    logic       wave_sel;
    logic [6:0] freq;
    logic [4:0] phase_ctrl;
    logic       key_flag;
    logic       sweep_on;

    int chk_cnt;
    int err_cnt;

    dds_param_ctrl #(
        .FREQ_MIN   (7'd1),
        .FREQ_MAX   (7'd4),
        .FREQ_INIT  (7'd1),
        .FREQ_STEP  (7'd1),
        .PHASE_STEP (5'd1),
        .DWELL_CNT  (24'd3)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_sweep   (key_sweep),
        .key_wave    (key_wave),
        .key_freq_up (key_freq_up),
        .key_freq_dn (key_freq_dn),
        .key_phase   (key_phase),
        .wave_sel    (wave_sel),
        .freq        (freq),
        .phase_ctrl  (phase_ctrl),
        .key_flag    (key_flag),
        .sweep_on    (sweep_on)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // keys = {sweep, wave, freq_up, freq_dn, phase}; held for one clock.
    task automatic pulse(input logic [4:0] keys);
        {key_sweep, key_wave, key_freq_up, key_freq_dn, key_phase} = keys;
        @(negedge sys_clk);
        {key_sweep, key_wave, key_freq_up, key_freq_dn, key_phase} = 5'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " wave_sel"},   int'(wave_sel),   0);
        check({tag, " freq"},       int'(freq),       1);
        check({tag, " phase_ctrl"}, int'(phase_ctrl), 0);
        check({tag, " key_flag"},   int'(key_flag),   0);
        check({tag, " sweep_on"},   int'(sweep_on),   0);
    endtask

    int t2_freq [8] = '{2, 3, 4, 3, 2, 1, 1, 1};
    int t2_flag [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    int sat_freq[4] = '{2, 3, 4, 4};
    int sat_flag[4] = '{1, 1, 1, 0};
    int t5_freq [7] = '{2, 3, 4, 3, 2, 1, 2};

    initial begin
        chk_cnt     = 0;
        err_cnt     = 0;
        sys_rst_n   = 1'b0;
        key_sweep   = 1'b0;
        key_wave    = 1'b0;
        key_freq_up = 1'b0;
        key_freq_dn = 1'b0;
        key_phase   = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // T1: idle after reset
        check_reset_vals("t1");

        // T2: 3 up, 5 down with saturation at FREQ_MIN
        for (int i = 0; i < 8; i++) begin
            pulse((i < 3) ? 5'b00100 : 5'b00010);
            check($sformatf("t2 freq[%0d]", i), int'(freq), t2_freq[i]);
            check($sformatf("t2 flag[%0d]", i), int'(key_flag), t2_flag[i]);
        end
        @(negedge sys_clk);
        check("t2 flag idle", int'(key_flag), 0);

        // T3: 33 phase presses, wraps 31 -> 0
        for (int i = 0; i < 33; i++) begin
            pulse(5'b00001);
            check($sformatf("t3 phase[%0d]", i), int'(phase_ctrl), (i + 1) % 32);
            check($sformatf("t3 flag[%0d]", i), int'(key_flag), 1);
        end
        @(negedge sys_clk);
        check("t3 flag idle", int'(key_flag), 0);

        // T4: wave beats freq_up in the same cycle
        pulse(5'b01100);
        check("t4 wave_sel", int'(wave_sel), 1);
        check("t4 freq", int'(freq), 1);
        check("t4 flag", int'(key_flag), 1);
        @(negedge sys_clk);
        check("t4 flag single", int'(key_flag), 0);

        // Manual up saturation at FREQ_MAX, no strobe on the no-op press
        for (int i = 0; i < 4; i++) begin
            pulse(5'b00100);
            check($sformatf("sat freq[%0d]", i), int'(freq), sat_freq[i]);
            check($sformatf("sat flag[%0d]", i), int'(key_flag), sat_flag[i]);
        end

        // Reset back to a known starting point for the sweep
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check_reset_vals("rst2");

        // T5: sweep with dwell of 4 clocks
        pulse(5'b10000);
        check("t5 sweep_on", int'(sweep_on), 1);
        check("t5 enter flag", int'(key_flag), 0);
        check("t5 enter freq", int'(freq), 1);
        for (int s = 0; s < 7; s++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge sys_clk);
                check($sformatf("t5 dwell flag[%0d.%0d]", s, c), int'(key_flag), 0);
            end
            @(negedge sys_clk);
            check($sformatf("t5 freq[%0d]", s), int'(freq), t5_freq[s]);
            check($sformatf("t5 flag[%0d]", s), int'(key_flag), 1);
            check($sformatf("t5 sweep_on[%0d]", s), int'(sweep_on), 1);
        end
        pulse(5'b10000);
        check("t5 exit sweep_on", int'(sweep_on), 0);
        check("t5 exit flag", int'(key_flag), 0);
        check("t5 exit freq", int'(freq), 2);
        repeat (10) @(negedge sys_clk);
        check("t5 frozen freq", int'(freq), 2);
        check("t5 frozen flag", int'(key_flag), 0);

        // T6: async reset mid-sweep
        pulse(5'b01000);
        check("t6 wave_sel", int'(wave_sel), 1);
        pulse(5'b10000);
        repeat (5) @(negedge sys_clk);
        check("t6 pre freq", int'(freq), 3);
        check("t6 pre sweep_on", int'(sweep_on), 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_reset_vals("t6 async");
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        check_reset_vals("t6 post");

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
